// File: rtl/instr_sequencer_if.sv
// Bus between the instruction sequencer and the imem / colour datapath slices.
// master = sequencer side, slave = imem + slices side.
interface instr_sequencer_if #(
  parameter int unsigned PC_W = 8
);
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data;
  logic [15:0]     opCode;
  logic            en;
  logic            WE;
  logic            BR_in;

  modport master (
    output imem_addr, opCode, en, WE,
    input  imem_data, BR_in
  );

  modport slave (
    input  imem_addr, opCode, en, WE,
    output imem_data, BR_in
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: owns the PC, runs a FETCH/ISSUE pair per instruction, resolves JMP/BR/HALT.
// Define INSTR_SEQ_CALL_EN to add the CALL/RET return stack and the sticky err flag.
//
// state  | meaning
// IDLE   | after reset, waiting for run
// FETCH  | imem_addr=pc, opCode latched from imem_data at the edge
// ISSUE  | opCode driven with en=1, next pc decided at the edge
// HALT   | stopped after HALT or a stack error, waiting for run
module instr_sequencer #(
  parameter int unsigned PC_W        = 8,
  parameter logic [3:0]  ST_CLASS    = 4'h3,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                run_i,
  input  logic                stall_i,
  instr_sequencer_if.master   bus,
  output logic [PC_W-1:0]     pc_o,
  output logic                halted_o,
  output logic                err_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALT} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc, target;
  logic [15:0]     opcode_q, opcode_d;
  logic            err_q, err_d;
  logic            issue_go;

  assign pc_inc   = pc_q + PC_W'(1);
  assign target   = opcode_q[PC_W-1:0];
  assign issue_go = (state_q == S_ISSUE) && !stall_i;

`ifdef INSTR_SEQ_CALL_EN
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

  logic [PC_W-1:0] stack_q [STACK_DEPTH];
  logic [SP_W-1:0] sp_q, sp_d, sp_dec;
  logic            push;

  assign sp_dec = sp_q - SP_W'(1);
`else
  logic unused_cfg;
  assign unused_cfg = ^STACK_DEPTH;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    err_d    = err_q;
`ifdef INSTR_SEQ_CALL_EN
    sp_d     = sp_q;
    push     = 1'b0;
`endif
    if (!stall_i) begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (run_i) begin
            state_d = S_FETCH;
            err_d   = 1'b0;
          end
        end
        S_FETCH: begin
          opcode_d = bus.imem_data;
          state_d  = S_ISSUE;
        end
        S_ISSUE: begin
          state_d = S_FETCH;
          pc_d    = pc_inc;
          case (opcode_q[15:12])
            4'hF: state_d = S_HALT;
            4'hE: pc_d = target;
            4'hD: if (bus.BR_in) pc_d = target;
`ifdef INSTR_SEQ_CALL_EN
            // Stack faults halt past the faulting op so run resumes after it.
            4'hC: begin
              if (sp_q == SP_W'(STACK_DEPTH)) begin
                err_d   = 1'b1;
                state_d = S_HALT;
              end else begin
                push = 1'b1;
                sp_d = sp_q + SP_W'(1);
                pc_d = target;
              end
            end
            4'hB: begin
              if (sp_q == '0) begin
                err_d   = 1'b1;
                state_d = S_HALT;
              end else begin
                sp_d = sp_dec;
                pc_d = stack_q[sp_dec[IDX_W-1:0]];
              end
            end
`endif
            default: ;
          endcase
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      opcode_q <= '0;
      err_q    <= 1'b0;
`ifdef INSTR_SEQ_CALL_EN
      sp_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      err_q    <= err_d;
`ifdef INSTR_SEQ_CALL_EN
      sp_q     <= sp_d;
`endif
    end
  end

`ifdef INSTR_SEQ_CALL_EN
  always_ff @(posedge clk_i) begin
    if (rst_n_i && push) stack_q[sp_q[IDX_W-1:0]] <= pc_inc;
  end
`endif

  assign bus.imem_addr = pc_q;
  assign bus.opCode    = opcode_q;
  assign bus.en        = issue_go;
  assign bus.WE        = issue_go && (opcode_q[15:12] == ST_CLASS);
  assign pc_o          = pc_q;
  assign halted_o      = (state_q == S_HALT);
`ifdef INSTR_SEQ_CALL_EN
  assign err_o         = err_q;
`else
  assign err_o         = 1'b0;
`endif

endmodule
